// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the front end: fetch FSM states, bubble
// instruction and the control-transfer opcodes also decoded by branch_cond.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DISCARD = 2'd1,
      HOLD    = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INST   = 32'h0000_0013;

   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;

   // Redirect targets are always word aligned; the low two bits are dropped.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_unit_if_ex_reg.sv
// IF/EX pipeline register: holds by default, flush turns it into a bubble,
// load captures a new {pc, inst} as a valid instruction.
module if_ex_reg
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        load,
   input  logic [31:0] pc_d,
   input  logic [31:0] inst_d,
   output logic [31:0] pc_q,
   output logic [31:0] inst_q,
   output logic        valid_q
);

   // Flush has priority over load so a redirect can never let a
   // wrong-path instruction into EX.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= 32'h0;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else if (flush) begin
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else if (load) begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem
// requests, handles EX redirects and buffers responses that land in a stall.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_if_o,
   output logic [31:0] inst_if_o,
   output logic        valid_if_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  tgt_q, tgt_d;
   logic [31:0]  buf_q, buf_d;
   logic [31:0]  target;
   logic         ifex_flush;
   logic         ifex_load;
   logic [31:0]  ifex_pc;
   logic [31:0]  ifex_inst;

   assign target      = align_word(br_target_i);
   assign imem_addr_o = pc_q;
   assign imem_req_o  = rst_n && (state_q != HOLD);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         tgt_q   <= 32'h0;
         buf_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      tgt_d      = tgt_q;
      buf_d      = buf_q;
      ifex_flush = 1'b0;
      ifex_load  = 1'b0;
      ifex_pc    = pc_q;
      ifex_inst  = imem_rdata_i;

      unique case (state_q)
         FETCH: begin
            if (br_taken_i) begin
               ifex_flush = 1'b1;
               if (imem_rvalid_i) begin
                  pc_d = target;
               end else begin
                  // Request to the old PC is still in flight; park the
                  // target until its response has been swallowed.
                  tgt_d   = target;
                  state_d = DISCARD;
               end
            end else if (imem_rvalid_i && !stall_i) begin
               ifex_load = 1'b1;
               pc_d      = pc_q + 32'd4;
            end else if (imem_rvalid_i) begin
               buf_d   = imem_rdata_i;
               state_d = HOLD;
            end else if (!stall_i) begin
               ifex_flush = 1'b1;
            end
         end

         DISCARD: begin
            ifex_flush = 1'b1;
            if (br_taken_i) begin
               tgt_d = target;
            end
            if (imem_rvalid_i) begin
               pc_d    = br_taken_i ? target : tgt_q;
               state_d = FETCH;
            end
         end

         HOLD: begin
            if (br_taken_i) begin
               ifex_flush = 1'b1;
               pc_d       = target;
               state_d    = FETCH;
            end else if (!stall_i) begin
               // pc_q was left untouched when buffering, so it is the
               // PC of the buffered instruction.
               ifex_load = 1'b1;
               ifex_inst = buf_q;
               pc_d      = pc_q + 32'd4;
               state_d   = FETCH;
            end
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   if_ex_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_ex_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (ifex_flush),
      .load    (ifex_load),
      .pc_d    (ifex_pc),
      .inst_d  (ifex_inst),
      .pc_q    (pc_if_o),
      .inst_q  (inst_if_o),
      .valid_q (valid_if_o)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction
// memory returning addr ^ 32'hA5A5_A5A5.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_taken;
   logic [31:0] br_target;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc_if;
   logic [31:0] inst_if;
   logic        valid_if;

   int checks = 0;
   int errors = 0;
   int lat    = 0;
   int cnt;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .br_taken_i    (br_taken),
      .br_target_i   (br_target),
      .stall_i       (stall),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .pc_if_o       (pc_if),
      .inst_if_o     (inst_if),
      .valid_if_o    (valid_if)
   );

   // Memory model: responds once a request has been held for lat cycles.
   assign imem_rvalid = imem_req && (cnt == lat);
   assign imem_rdata  = imem_addr ^ KEY;

   always @(posedge clk) begin
      if (!rst_n || !imem_req || imem_rvalid) cnt <= 0;
      else                                    cnt <= cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; br_taken = 1'b0; br_target = 32'h0; stall = 1'b0; lat = 0;
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; br_taken = 1'b0; br_target = 32'h0; stall = 1'b0; lat = 0;
      step(); step();
      checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", valid_if); end
      checks++; if (inst_if !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", inst_if, NOP); end
      checks++; if (pc_if !== 32'h0) begin errors++; $display("FAIL reset_pc_if got %h want 0", pc_if); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %h want 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req got %h want 1", imem_req); end
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         step();
         checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d] got %h want %h", i, imem_addr, 32'(4 * i)); end
         checks++; if (pc_if !== 32'(4 * (i - 1))) begin errors++; $display("FAIL stream_pc_if[%0d] got %h want %h", i, pc_if, 32'(4 * (i - 1))); end
         checks++; if (inst_if !== (32'(4 * (i - 1)) ^ KEY)) begin errors++; $display("FAIL stream_inst[%0d] got %h want %h", i, inst_if, 32'(4 * (i - 1)) ^ KEY); end
         checks++; if (valid_if !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %h want 1", i, valid_if); end
      end
   endtask

   task automatic test_branch();
      do_reset();
      repeat (4) step();
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL br_setup_addr got %h want 00000010", imem_addr); end
      br_taken = 1'b1; br_target = 32'h0000_0103;
      step();
      br_taken = 1'b0;
      checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL br_flush_valid got %h want 0", valid_if); end
      checks++; if (inst_if !== NOP) begin errors++; $display("FAIL br_flush_inst got %h want %h", inst_if, NOP); end
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL br_addr got %h want 00000100", imem_addr); end
      step();
      checks++; if (pc_if !== 32'h100 || valid_if !== 1'b1) begin errors++; $display("FAIL br_target_load got pc=%h v=%h want pc=00000100 v=1", pc_if, valid_if); end
      checks++; if (inst_if !== 32'hA5A5_A4A5) begin errors++; $display("FAIL br_target_inst got %h want a5a5a4a5", inst_if); end
   endtask

   task automatic test_discard();
      do_reset();
      repeat (8) step();
      lat = 3;
      step();
      checks++; if (valid_if !== 1'b0) begin errors++; $display("FAIL disc_wait_bubble got %h want 0", valid_if); end
      br_taken = 1'b1; br_target = 32'h0000_0200;
      step();
      br_taken = 1'b0;
      checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin errors++; $display("FAIL disc_hold_addr got %h req=%h want 00000020 req=1", imem_addr, imem_req); end
      step();
      checks++; if (imem_addr !== 32'h20 || imem_rvalid !== 1'b1) begin errors++; $display("FAIL disc_resp_addr got %h rv=%h want 00000020 rv=1", imem_addr, imem_rvalid); end
      step();
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL disc_new_addr got %h want 00000200", imem_addr); end
      checks++; if (valid_if !== 1'b0 || inst_if !== NOP) begin errors++; $display("FAIL disc_dropped got v=%h inst=%h want v=0 inst=%h", valid_if, inst_if, NOP); end
      lat = 0;
      step();
      checks++; if (pc_if !== 32'h200 || inst_if !== 32'hA5A5_A7A5 || valid_if !== 1'b1) begin errors++; $display("FAIL disc_resume got pc=%h inst=%h v=%h want 00000200 a5a5a7a5 1", pc_if, inst_if, valid_if); end
   endtask

   task automatic test_stall();
      do_reset();
      repeat (12) step();
      checks++; if (imem_addr !== 32'h30) begin errors++; $display("FAIL stall_setup_addr got %h want 00000030", imem_addr); end
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %h want 0", i, imem_req); end
         checks++; if (pc_if !== 32'h2C || inst_if !== 32'hA5A5_A589 || valid_if !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got pc=%h inst=%h v=%h want 0000002c a5a5a589 1", i, pc_if, inst_if, valid_if); end
      end
      stall = 1'b0;
      step();
      checks++; if (pc_if !== 32'h30 || inst_if !== 32'hA5A5_A595 || valid_if !== 1'b1) begin errors++; $display("FAIL stall_release got pc=%h inst=%h v=%h want 00000030 a5a5a595 1", pc_if, inst_if, valid_if); end
      checks++; if (imem_addr !== 32'h34 || imem_req !== 1'b1) begin errors++; $display("FAIL stall_next_addr got %h req=%h want 00000034 req=1", imem_addr, imem_req); end
   endtask

   task automatic test_back_to_back();
      bit done = 1'b0;
      bit saw_400 = 1'b0;
      do_reset();
      repeat (2) step();
      lat = 5;
      br_taken = 1'b1; br_target = 32'h0000_0400;
      step();
      br_taken = 1'b0;
      step();
      br_taken = 1'b1; br_target = 32'h0000_0500;
      step();
      br_taken = 1'b0;
      checks++; if (imem_addr !== 32'h8 || valid_if !== 1'b0) begin errors++; $display("FAIL b2b_pending got addr=%h v=%h want 00000008 0", imem_addr, valid_if); end
      for (int i = 0; i < 10 && !done; i++) begin
         step();
         if (imem_addr == 32'h400) saw_400 = 1'b1;
         if (imem_addr != 32'h8) done = 1'b1;
      end
      checks++; if (!done) begin errors++; $display("FAIL b2b_timeout got addr=%h want 00000500", imem_addr); end
      checks++; if (imem_addr !== 32'h500 || saw_400) begin errors++; $display("FAIL b2b_target got %h saw400=%0d want 00000500 saw400=0", imem_addr, saw_400); end
   endtask

   task automatic test_reset_mid_discard();
      do_reset();
      lat = 4;
      br_taken = 1'b1; br_target = 32'h0000_0600;
      step();
      br_taken = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_gate_req got %h want 0", imem_req); end
      step();
      checks++; if (imem_addr !== 32'h0 || valid_if !== 1'b0 || inst_if !== NOP) begin errors++; $display("FAIL rst_mid got addr=%h v=%h inst=%h want 0 0 %h", imem_addr, valid_if, inst_if, NOP); end
      rst_n = 1'b1; lat = 0;
      step();
      checks++; if (pc_if !== 32'h0 || valid_if !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL rst_mid_fetch got pc=%h v=%h addr=%h want 0 1 00000004", pc_if, valid_if, imem_addr); end
   endtask

   task automatic test_wrap();
      do_reset();
      br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
      step();
      br_taken = 1'b0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h want fffffffc", imem_addr); end
      step();
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 00000000", imem_addr); end
      checks++; if (pc_if !== 32'hFFFF_FFFC || inst_if !== 32'h5A5A_5A59 || valid_if !== 1'b1) begin errors++; $display("FAIL wrap_ifex got pc=%h inst=%h v=%h want fffffffc 5a5a5a59 1", pc_if, inst_if, valid_if); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_branch();
      test_discard();
      test_stall();
      test_back_to_back();
      test_reset_mid_discard();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
